// File: rtl/dma_csr_if.sv
// Flat CSR bus between the AXI-lite slave (master side) and a CSR register
// file (slave side).
//   csr_addr/csr_wen/csr_ren/csr_wdata : master -> slave
//   csr_rdata/csr_hit                  : slave -> master, combinational from csr_addr
interface dma_csr_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] csr_addr;
  logic              csr_wen;
  logic              csr_ren;
  logic [DATA_W-1:0] csr_wdata;
  logic [DATA_W-1:0] csr_rdata;
  logic              csr_hit;

  modport master (output csr_addr, csr_wen, csr_ren, csr_wdata,
                  input  csr_rdata, csr_hit);
  modport slave  (input  csr_addr, csr_wen, csr_ren, csr_wdata,
                  output csr_rdata, csr_hit);
endinterface

// File: rtl/dma_csr_regfile.sv
// DMA control CSR window (0x50..0x54).
// Holds the DMA configuration, issues one-cycle start/abort pulses to the
// engine, tracks busy / sticky done+err / completion count and drives a
// registered level interrupt.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   bus (slave)           flat CSR bus: addr/wen/ren/wdata in, rdata/hit out
//   dma_layer/count/burst configuration outputs
//   dma_start/dma_abort   1-cycle command pulses to the engine
//   dma_done/dma_error    1-cycle event pulses from the engine
//   irq                   IRQ_EN & (DONE | ERR), one cycle behind the status bits
module dma_csr_regfile #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 64,
  parameter int DEF_BURST = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  dma_csr_if.slave     bus,
  output logic [7:0]   dma_layer,
  output logic [31:0]  dma_count,
  output logic [7:0]   dma_burst,
  output logic         dma_start,
  output logic         dma_abort,
  input  logic         dma_done,
  input  logic         dma_error,
  output logic         irq
);

  localparam logic [ADDR_W-1:0] A_LAYER  = ADDR_W'(8'h50);
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(8'h51);
  localparam logic [ADDR_W-1:0] A_COUNT  = ADDR_W'(8'h52);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(8'h53);
  localparam logic [ADDR_W-1:0] A_BURST  = ADDR_W'(8'h54);

  logic [7:0]  layer_q, layer_d;
  logic [31:0] count_q, count_d;
  logic [7:0]  burst_q, burst_d;
  logic        irq_en_q, irq_en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] xfer_q, xfer_d;
  logic        start_q, start_d;
  logic        abort_q, abort_d;
  logic        irq_q, irq_d;

  logic wr_ctrl, wr_status, cfg_wr_ok, start_req, abort_req, done_ev;
  logic unused_ren;

  // Read path is purely combinational; the read strobe carries no meaning here.
  assign unused_ren = bus.csr_ren;

  always_comb begin
    wr_ctrl   = bus.csr_wen && (bus.csr_addr == A_CTRL);
    wr_status = bus.csr_wen && (bus.csr_addr == A_STATUS);
    // Configuration is frozen while a transfer is in flight.
    cfg_wr_ok = bus.csr_wen && !busy_q;
    start_req = wr_ctrl && bus.csr_wdata[0];
    abort_req = wr_ctrl && bus.csr_wdata[1];
    // Completions only count against a transfer we actually started.
    done_ev   = dma_done && busy_q;

    layer_d  = layer_q;
    count_d  = count_q;
    burst_d  = burst_q;
    irq_en_d = irq_en_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    xfer_d   = xfer_q;
    start_d  = 1'b0;
    abort_d  = 1'b0;

    if (cfg_wr_ok && bus.csr_addr == A_LAYER) layer_d = bus.csr_wdata[7:0];
    if (cfg_wr_ok && bus.csr_addr == A_COUNT) count_d = bus.csr_wdata[31:0];
    if (cfg_wr_ok && bus.csr_addr == A_BURST) begin
      if (bus.csr_wdata == '0)
        burst_d = 8'd1;
      else if (bus.csr_wdata > DATA_W'(MAX_BURST))
        burst_d = 8'(MAX_BURST);
      else
        burst_d = bus.csr_wdata[7:0];
    end
    if (wr_ctrl) irq_en_d = bus.csr_wdata[2];

    // Command handling: abort dominates start; start while busy is an error.
    if (abort_req) begin
      abort_d = 1'b1;
      busy_d  = 1'b0;
    end else if (start_req) begin
      if (busy_q) err_d = 1'b1;
      else begin
        start_d = 1'b1;
        busy_d  = 1'b1;
      end
    end

    // W1C first so that a coincident hardware set overrides the clear.
    if (wr_status && bus.csr_wdata[1]) done_d = 1'b0;
    if (wr_status && bus.csr_wdata[2]) err_d  = 1'b0;

    if (done_ev) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      xfer_d = xfer_q + 16'd1;
    end
    if (dma_error) begin
      busy_d = 1'b0;
      err_d  = 1'b1;
    end

    irq_d = irq_en_q && (done_q || err_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer_q  <= '0;
      count_q  <= '0;
      burst_q  <= 8'(DEF_BURST);
      irq_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      xfer_q   <= '0;
      start_q  <= 1'b0;
      abort_q  <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      layer_q  <= layer_d;
      count_q  <= count_d;
      burst_q  <= burst_d;
      irq_en_q <= irq_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      xfer_q   <= xfer_d;
      start_q  <= start_d;
      abort_q  <= abort_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    bus.csr_rdata = '0;
    bus.csr_hit   = 1'b1;
    case (bus.csr_addr)
      A_LAYER:  bus.csr_rdata = DATA_W'(layer_q);
      A_CTRL:   bus.csr_rdata = DATA_W'({irq_en_q, 2'b00});
      A_COUNT:  bus.csr_rdata = DATA_W'(count_q);
      A_STATUS: bus.csr_rdata = DATA_W'({xfer_q, 13'd0, err_q, done_q, busy_q});
      A_BURST:  bus.csr_rdata = DATA_W'(burst_q);
      default:  bus.csr_hit   = 1'b0;
    endcase
  end

  assign dma_layer = layer_q;
  assign dma_count = count_q;
  assign dma_burst = burst_q;
  assign dma_start = start_q;
  assign dma_abort = abort_q;
  assign irq       = irq_q;

endmodule
